// File: rtl/digit_serial_adder_pkg.sv
// Shared definitions for digit_serial_adder: FSM state encoding and
// elaboration-time parameter helpers.
package digit_serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Legal when CHUNK is 1..WIDTH and divides WIDTH exactly.
   function automatic bit cfg_ok(int unsigned width, int unsigned chunk);
      return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
   endfunction

   function automatic int unsigned cnt_width(int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/digit_serial_adder_chunk_adder.sv
// CHUNK-bit ripple-carry slice built from single-bit full-adder cells.
// c_msb is the carry into the top cell, used for signed overflow.
module chunk_adder #(
   parameter int unsigned CHUNK = 4
) (
   input  logic [CHUNK-1:0] x,
   input  logic [CHUNK-1:0] y,
   input  logic             ci,
   output logic [CHUNK-1:0] s,
   output logic             co,
   output logic             c_msb
);

   logic [CHUNK:0] c;

   assign c[0] = ci;

   for (genvar i = 0; i < CHUNK; i++) begin : g_fa
      assign s[i]   = x[i] ^ y[i] ^ c[i];
      assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
   end

   assign co    = c[CHUNK];
   assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle adder: WIDTH-bit operands added CHUNK bits per clock.
// Define SUB_EN to add the sub port (A + ~B + 1 per operation).
module digit_serial_adder
   import digit_serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned N  = WIDTH / CHUNK;
   localparam int unsigned CW = cnt_width(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   if (!cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
      $error("digit_serial_adder: WIDTH must be a non-zero multiple of CHUNK");
   end

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] a_sh, b_sh;
   logic             carry_q;
   logic             load, step, finish;

   logic [WIDTH-1:0] b_in;
   logic             carry_in;

`ifdef SUB_EN
   assign b_in     = sub ? ~b : b;
   assign carry_in = sub ? 1'b1 : cin;
`else
   assign b_in     = b;
   assign carry_in = cin;
`endif

   logic [CHUNK-1:0] ch_s;
   logic             ch_co, ch_cmsb;
   logic [WIDTH-1:0] r_next;

   chunk_adder #(.CHUNK(CHUNK)) u_chunk (
      .x     (a_sh[CHUNK-1:0]),
      .y     (b_sh[CHUNK-1:0]),
      .ci    (carry_q),
      .s     (ch_s),
      .co    (ch_co),
      .c_msb (ch_cmsb)
   );

   // Partial results enter from the top; only the WIDTH-CHUNK bits still
   // needed by later chunks are kept, so the single-chunk case has no store.
   if (N > 1) begin : g_acc
      logic [WIDTH-CHUNK-1:0] acc;
      always_ff @(posedge clk or posedge rst) begin
         if (rst)       acc <= '0;
         else if (step) acc <= r_next[WIDTH-1:CHUNK];
      end
      assign r_next = {ch_s, acc};
   end else begin : g_noacc
      assign r_next = ch_s;
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      step    = 1'b0;
      finish  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               load    = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (cnt_q == LAST) begin
               finish  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            if (start) begin
               load    = 1'b1;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_sh    <= '0;
         b_sh    <= '0;
         carry_q <= 1'b0;
         sum     <= '0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (load) begin
            cnt_q   <= '0;
            a_sh    <= a;
            b_sh    <= b_in;
            carry_q <= carry_in;
         end else if (step) begin
            cnt_q   <= cnt_q + 1'b1;
            a_sh    <= a_sh >> CHUNK;
            b_sh    <= b_sh >> CHUNK;
            carry_q <= ch_co;
         end
         if (finish) begin
            sum  <= r_next;
            cout <= ch_co;
            ovf  <= ch_co ^ ch_cmsb;
         end
      end
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed self-checking bench for digit_serial_adder (16/4 and 8/8 builds);
// subtract vectors run only when SUB_EN is defined.
module tb_digit_serial_adder;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] a, b;
   logic        cin;
   logic        busy, done;
   logic [15:0] sum;
   logic        cout, ovf;
`ifdef SUB_EN
   logic        sub;
   logic        sub8;
`endif

   logic        start8;
   logic [7:0]  a8, b8;
   logic        cin8;
   logic        busy8, done8;
   logic [7:0]  sum8;
   logic        cout8, ovf8;

   int n_checks = 0;
   int n_fail   = 0;
   logic [15:0] last_sum;

   always #5 clk = ~clk;

   digit_serial_adder #(.WIDTH(16), .CHUNK(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
`ifdef SUB_EN
      .sub   (sub),
`endif
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf)
   );

   digit_serial_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
      .clk   (clk),
      .rst   (rst),
      .start (start8),
      .a     (a8),
      .b     (b8),
      .cin   (cin8),
`ifdef SUB_EN
      .sub   (sub8),
`endif
      .busy  (busy8),
      .done  (done8),
      .sum   (sum8),
      .cout  (cout8),
      .ovf   (ovf8)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_op(input logic [15:0] av, input logic [15:0] bv,
                           input logic cv, input logic sv);
      a     = av;
      b     = bv;
      cin   = cv;
`ifdef SUB_EN
      sub   = sv;
`else
      if (sv) $display("subtract requested without SUB_EN");
`endif
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Counts busy cycles (bounded) and checks sum holds its prior value meanwhile.
   task automatic wait_done(input string tag, output int cycles);
      cycles = 0;
      while (busy && cycles < 20) begin
         check({tag, "_hold"}, sum, last_sum);
         cycles++;
         tick();
      end
   endtask

   task automatic check_result(input string tag, input logic [15:0] es,
                               input logic ec, input logic eo);
      check({tag, "_done"}, done, 1'b1);
      check({tag, "_sum"},  sum,  es);
      check({tag, "_cout"}, cout, ec);
      check({tag, "_ovf"},  ovf,  eo);
      last_sum = es;
   endtask

   task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic cv, input logic sv,
                         input logic [15:0] es, input logic ec, input logic eo);
      int c;
      start_op(av, bv, cv, sv);
      wait_done(tag, c);
      check({tag, "_busy_cycles"}, c, 4);
      check_result(tag, es, ec, eo);
      tick();
      check({tag, "_done_clear"}, done, 1'b0);
      check({tag, "_idle"}, busy, 1'b0);
   endtask

   initial begin
      int   c;
      logic seen;

      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
`ifdef SUB_EN
      sub = 1'b0; sub8 = 1'b0;
`endif
      last_sum = '0;
      #3;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_sum",  sum,  16'h0000);
      check("rst_cout", cout, 1'b0);
      check("rst_ovf",  ovf,  1'b0);
      tick();
      tick();
      rst = 1'b0;
      tick();

      run_op("carry_chain", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
      run_op("wrap",        16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_op("pos_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      run_op("cin_add",     16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
`ifdef SUB_EN
      run_op("sub_borrow",  16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      run_op("sub_cin_ign", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      run_op("sub_ovf",     16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif

      // Back-to-back: start held in the DONE cycle.
      start_op(16'h0F0F, 16'h0101, 1'b0, 1'b0);
      wait_done("b2b_first", c);
      check("b2b_first_cycles", c, 4);
      check_result("b2b_first", 16'h1010, 1'b0, 1'b0);
      start_op(16'h8000, 16'h8000, 1'b0, 1'b0);
      check("b2b_busy", busy, 1'b1);
      check("b2b_no_done", done, 1'b0);
      wait_done("b2b_second", c);
      check("b2b_second_cycles", c, 4);
      check_result("b2b_second", 16'h0000, 1'b1, 1'b1);
      tick();
      check("b2b_done_clear", done, 1'b0);

      // Start pulsed during RUN must be ignored.
      start_op(16'hFFFF, 16'h3334, 1'b0, 1'b0);
      tick();
      a = 16'h0000; b = 16'h0000; start = 1'b1;
      tick();
      start = 1'b0;
      wait_done("ignore", c);
      check("ignore_cycles", c, 2);
      check_result("ignore", 16'h3333, 1'b1, 1'b0);
      tick();
      check("ignore_done_clear", done, 1'b0);

      // Asynchronous reset in RUN cycle 2.
      start_op(16'h0001, 16'h0001, 1'b0, 1'b0);
      tick();
      rst = 1'b1;
      #2;
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_done", done, 1'b0);
      check("mid_rst_sum",  sum,  16'h0000);
      check("mid_rst_cout", cout, 1'b0);
      check("mid_rst_ovf",  ovf,  1'b0);
      tick();
      rst = 1'b0;
      last_sum = 16'h0000;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         seen = seen | done | busy;
      end
      check("post_rst_quiet", seen, 1'b0);
      run_op("post_rst_op", 16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);

      // Single-chunk build: done one cycle after acceptance.
      a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      check("n1_busy", busy8, 1'b1);
      tick();
      check("n1_done", done8, 1'b1);
      check("n1_sum",  sum8,  8'h00);
      check("n1_cout", cout8, 1'b1);
      check("n1_ovf",  ovf8,  1'b0);
      tick();
      check("n1_done_clear", done8, 1'b0);
      a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      tick();
      check("n1_ovf_done", done8, 1'b1);
      check("n1_ovf_sum",  sum8,  8'h80);
      check("n1_ovf_cout", cout8, 1'b0);
      check("n1_ovf_ovf",  ovf8,  1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
